// File: rtl/msb_decode_pipe.sv
// Leading-one decoder: rebuilds a 32-bit word from {zero, pos, frac} via a 5-stage right-shift pipeline.
// Latency 5 cycles; one beat/cycle; whole pipe freezes (bubbles kept) while out_valid && !out_ready.
module msb_decode_pipe (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_zero,
    input  logic [4:0]  in_pos,
    input  logic [30:0] in_frac,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    logic        adv;
    logic [4:0]  shamt;
    logic [31:0] word0;

    logic [4:0]  vld_d,  vld_q;
    logic [31:0] word1_d, word1_q;
    logic [31:0] word2_d, word2_q;
    logic [31:0] word3_d, word3_q;
    logic [31:0] word4_d, word4_q;
    logic [31:0] word5_d, word5_q;
    logic [3:0]  sh1_d, sh1_q;
    logic [2:0]  sh2_d, sh2_q;
    logic [1:0]  sh3_d, sh3_q;
    logic        sh4_d, sh4_q;

    // 31 - pos is just the bitwise inverse of a 5-bit value
    assign shamt = ~in_pos;
    assign word0 = in_zero ? 32'h0 : {1'b1, in_frac};
    assign adv   = !vld_q[4] || out_ready;

    always_comb begin
        vld_d   = vld_q;
        word1_d = word1_q;
        word2_d = word2_q;
        word3_d = word3_q;
        word4_d = word4_q;
        word5_d = word5_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        sh3_d   = sh3_q;
        sh4_d   = sh4_q;
        if (adv) begin
            vld_d   = {vld_q[3:0], in_valid};
            word1_d = shamt[4] ? (word0   >> 16) : word0;
            sh1_d   = shamt[3:0];
            word2_d = sh1_q[3] ? (word1_q >> 8)  : word1_q;
            sh2_d   = sh1_q[2:0];
            word3_d = sh2_q[2] ? (word2_q >> 4)  : word2_q;
            sh3_d   = sh2_q[1:0];
            word4_d = sh3_q[1] ? (word3_q >> 2)  : word3_q;
            sh4_d   = sh3_q[0];
            word5_d = sh4_q    ? (word4_q >> 1)  : word4_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q   <= '0;
            word1_q <= '0;
            word2_q <= '0;
            word3_q <= '0;
            word4_q <= '0;
            word5_q <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            sh3_q   <= '0;
            sh4_q   <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            word1_q <= word1_d;
            word2_q <= word2_d;
            word3_q <= word3_d;
            word4_q <= word4_d;
            word5_q <= word5_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            sh3_q   <= sh3_d;
            sh4_q   <= sh4_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[4];
    assign out_data  = word5_q;

endmodule

// File: tb/tb_msb_decode_pipe.sv
// Self-checking bench for msb_decode_pipe: directed table, latency, backpressure, bubbles, reset, round-trip sweep.
module tb_msb_decode_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_zero = 1'b0;
    logic [4:0]  in_pos = '0;
    logic [30:0] in_frac = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    msb_decode_pipe dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_zero   (in_zero),
        .in_pos    (in_pos),
        .in_frac   (in_frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        z;
        logic [4:0]  p;
        logic [30:0] f;
        logic [31:0] e;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    int          out_times[$];
    bit          rand_rdy = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] decode_ref(input logic z, input logic [4:0] p, input logic [30:0] f);
        logic [31:0] w;
        w = {1'b1, f};
        return z ? 32'h0 : (w >> (5'd31 - p));
    endfunction

    function automatic void encode(input logic [31:0] w, output logic [4:0] p, output logic [30:0] f);
        logic [31:0] sh;
        p = 5'd0;
        for (int i = 0; i < 32; i++)
            if (w[i]) p = 5'(i);
        sh = w << (5'd31 - p);
        f  = sh[30:0];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: scoreboard pop, stall hold and in_ready checks
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", out_data, held);
            end
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected none (cycle %0d)", out_data, cyc);
                end else begin
                    check("data", out_data, exp_q.pop_front());
                end
                out_times.push_back(cyc);
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
        end
    end

    // Presents one beat from posedge+1 and holds it until accepted
    task automatic send(input logic z, input logic [4:0] p, input logic [30:0] f, input logic [31:0] e);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_zero  = z;
        in_pos   = p;
        in_frac  = f;
        for (int i = 0; i < 1000 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected accept (cycle %0d)", cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [4:0]  p;
        logic [30:0] f;
        encode(w, p, f);
        send(1'b0, p, f, w);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom >> $urandom_range(0, 31);
        return (w == 32'h0) ? 32'h1 : w;
    endfunction

    initial begin
        vec_t vt[7];
        int   t0;
        vt[0] = '{1'b0, 5'd31, 31'h0000_0000, 32'h8000_0000};
        vt[1] = '{1'b0, 5'd0,  31'h7FFF_FFFF, 32'h0000_0001};
        vt[2] = '{1'b0, 5'd4,  31'h3000_0000, 32'h0000_0016};
        vt[3] = '{1'b1, 5'd17, 31'h5555_5555, 32'h0000_0000};
        vt[4] = '{1'b0, 5'd16, 31'h11A2_8000, 32'h0001_2345};
        vt[5] = '{1'b0, 5'd31, 31'h7FFF_FFFF, 32'hFFFF_FFFF};
        vt[6] = '{1'b1, 5'd0,  31'h0000_0000, 32'h0000_0000};

        rstn = 1'b0;
        idle(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1;
        out_ready = 1'b1;
        idle(2);

        // Directed table: value and exact 5-cycle latency
        for (int i = 0; i < 7; i++) begin
            out_times.delete();
            t0 = cyc;
            send(vt[i].z, vt[i].p, vt[i].f, vt[i].e);
            idle(7);
            check("lat_count", 32'(out_times.size()), 32'd1);
            if (out_times.size() > 0) check("lat", 32'(out_times[0]), 32'(t0 + 5));
        end

        // Back-to-back: 8 results on consecutive cycles
        out_times.delete();
        t0 = cyc;
        for (int i = 0; i < 8; i++) send_word(rand_word());
        idle(8);
        check("b2b_count", 32'(out_times.size()), 32'd8);
        for (int i = 0; i < out_times.size(); i++) check("b2b_time", 32'(out_times[i]), 32'(t0 + 5 + i));

        // Backpressure with a full pipeline
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_word(rand_word());
        in_valid = 1'b1;
        in_zero  = 1'b0;
        in_pos   = 5'd9;
        in_frac  = 31'h2AAA_AAAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(1'b0, 5'd9, 31'h2AAA_AAAA, decode_ref(1'b0, 5'd9, 31'h2AAA_AAAA));
        idle(10);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Bubbles with random downstream ready
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [4:0]  p;
            logic [30:0] f;
            logic        z;
            p = 5'($urandom_range(0, 31));
            f = 31'($urandom);
            z = ($urandom_range(0, 7) == 0);
            send(z, p, f, decode_ref(z, p, f));
            idle(1);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        idle(12);
        check("bubble_drained", 32'(exp_q.size()), 32'd0);

        // Reset with 3 beats in flight
        for (int i = 0; i < 3; i++) send_word(rand_word());
        rstn = 1'b0;
        exp_q.delete();
        idle(1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'h0);
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // Round-trip sweep through the reference encoder
        for (int i = 0; i < 10000; i++) send_word(rand_word());
        idle(10);
        check("sweep_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
